// File: rtl/common_fifo_ram_2w2r.sv
// common_fifo_ram_2w2r: two-wide FWFT FIFO with reset preload (e.g. a 2-wide rename free list).
// Latency: a push is visible on dout one edge after the write; status is combinational from the pointers.
// Backpressure: none internally; the caller checks full/full2/empty/single. COMMON_FIFO_RAM_2W2R_GUARD_EN clips illegal lanes instead.
module common_fifo_ram_2w2r #(
  parameter int FIFO_DEPTH_LOG2 = 4,
  parameter int FIFO_WIDTH = 6,
  parameter logic [FIFO_DEPTH_LOG2:0] FIFO_RESET_STATE = (FIFO_DEPTH_LOG2+1)'(2**FIFO_DEPTH_LOG2),
  parameter logic [(2**FIFO_DEPTH_LOG2)*FIFO_WIDTH-1:0] FIFO_RESET_VALUE = {
    6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7,
    6'd8, 6'd9, 6'd10, 6'd11, 6'd12, 6'd13, 6'd14, 6'd15}
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [FIFO_WIDTH-1:0]     din0,
  input  logic [FIFO_WIDTH-1:0]     din1,
  input  logic                      wen0,
  input  logic                      wen1,
  output logic [FIFO_WIDTH-1:0]     dout0,
  output logic [FIFO_WIDTH-1:0]     dout1,
  input  logic                      ren0,
  input  logic                      ren1,
  output logic [FIFO_DEPTH_LOG2:0]  fifo_count,
  output logic                      fifo_empty,
  output logic                      fifo_single,
  output logic                      fifo_full,
  output logic                      fifo_full2
);

  localparam int DEPTH = 2**FIFO_DEPTH_LOG2;
  localparam int AW = FIFO_DEPTH_LOG2;
  localparam int PW = FIFO_DEPTH_LOG2 + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [PW-1:0] ONE_P = PW'(1);

  logic [FIFO_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] rptr;
  logic [PW-1:0] wptr;
  logic [PW-1:0] count;
  logic [AW-1:0] wa0;
  logic [AW-1:0] wa1;
  logic [AW-1:0] ra0;
  logic [AW-1:0] ra1;
  logic push0;
  logic push1;
  logic pop0;
  logic pop1;
  logic [1:0] npush;
  logic [1:0] npop;

  // Occupancy from the wrap-bit pointers; the extra bit separates full from empty.
  assign count = wptr - rptr;
  assign fifo_count = count;
  assign fifo_empty = (count == '0);
  assign fifo_single = (count <= ONE_P);
  assign fifo_full = (count == DEPTH_P);
  assign fifo_full2 = (count >= (DEPTH_P - ONE_P));

  // Lane addresses wrap independently inside the RAM index space.
  assign wa0 = wptr[AW-1:0];
  assign wa1 = wa0 + AW'(1);
  assign ra0 = rptr[AW-1:0];
  assign ra1 = ra0 + AW'(1);

  assign dout0 = mem[ra0];
  assign dout1 = mem[ra1];

`ifdef COMMON_FIFO_RAM_2W2R_GUARD_EN
  // Lanes are accepted against the pre-edge occupancy only: pops give no credit to pushes.
  assign push0 = wen0 & ~fifo_full;
  assign push1 = wen0 & wen1 & ~fifo_full2;
  assign pop0 = ren0 & ~fifo_empty;
  assign pop1 = ren0 & ren1 & ~fifo_single;
`else
  // Caller guarantees legality; lane 1 is only honoured alongside lane 0.
  assign push0 = wen0;
  assign push1 = wen0 & wen1;
  assign pop0 = ren0;
  assign pop1 = ren0 & ren1;
`endif

  assign npush = {1'b0, push0} + {1'b0, push1};
  assign npop = {1'b0, pop0} + {1'b0, pop1};

  // Pointer update: both advance on the same edge, reset restores the preload occupancy.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rptr <= '0;
      wptr <= FIFO_RESET_STATE;
    end else begin
      rptr <= rptr + PW'(npop);
      wptr <= wptr + PW'(npush);
    end
  end

  // Storage: reset loads entry k from the packed preload, otherwise write the accepted lanes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem[k] <= FIFO_RESET_VALUE[(DEPTH-1-k)*FIFO_WIDTH +: FIFO_WIDTH];
      end
    end else begin
      if (push0) mem[wa0] <= din0;
      if (push1) mem[wa1] <= din1;
    end
  end

endmodule

// File: tb/tb_common_fifo_ram_2w2r.sv
// Directed bench for common_fifo_ram_2w2r with default parameters.
// Table vectors cover drain, refill, lane ordering and simultaneous push/pop;
// a queue model drives the wrap, async-reset and (when enabled) guard sequences.
module tb_common_fifo_ram_2w2r;

  localparam int D = 16;

  logic clk = 1'b0;
  logic resetn;
  logic [5:0] din0, din1, dout0, dout1;
  logic wen0, wen1, ren0, ren1;
  logic [4:0] fifo_count;
  logic fifo_empty, fifo_single, fifo_full, fifo_full2;

  int nvec = 0;
  int nerr = 0;

  logic [5:0] q[$];

  typedef struct {
    logic       w0;
    logic       w1;
    logic [5:0] d0;
    logic [5:0] d1;
    logic       r0;
    logic       r1;
    int         cnt;
    int         o0;
    int         o1;
  } vec_t;

  vec_t vt[21];

  always #5 clk = ~clk;

  common_fifo_ram_2w2r dut (
    .clk(clk), .resetn(resetn),
    .din0(din0), .din1(din1), .wen0(wen0), .wen1(wen1),
    .dout0(dout0), .dout1(dout1), .ren0(ren0), .ren1(ren1),
    .fifo_count(fifo_count), .fifo_empty(fifo_empty), .fifo_single(fifo_single),
    .fifo_full(fifo_full), .fifo_full2(fifo_full2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag, input int c, input int o0, input int o1);
    chk({tag, " count"}, 32'(fifo_count), 32'(c));
    chk({tag, " empty"}, 32'(fifo_empty), 32'(c == 0));
    chk({tag, " single"}, 32'(fifo_single), 32'(c <= 1));
    chk({tag, " full"}, 32'(fifo_full), 32'(c == D));
    chk({tag, " full2"}, 32'(fifo_full2), 32'(c >= D - 1));
    if (c >= 1) chk({tag, " dout0"}, 32'(dout0), 32'(o0));
    if (c >= 2) chk({tag, " dout1"}, 32'(dout1), 32'(o1));
  endtask

  task automatic idle();
    wen0 = 1'b0; wen1 = 1'b0; ren0 = 1'b0; ren1 = 1'b0;
    din0 = '0; din1 = '0;
  endtask

  task automatic do_reset();
    idle();
    @(negedge clk);
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    q.delete();
    for (int i = 0; i < D; i++) q.push_back(6'(i));
  endtask

  // One cycle against the queue model; expected values come from the model, not the DUT.
  task automatic step(input string tag, input logic w0, input logic w1, input logic [5:0] d0,
                      input logic [5:0] d1, input logic r0, input logic r1);
    int np;
    int nq;
    int sz;
    np = w0 ? (w1 ? 2 : 1) : 0;
    nq = r0 ? (r1 ? 2 : 1) : 0;
    sz = q.size();
`ifdef COMMON_FIFO_RAM_2W2R_GUARD_EN
    if (np > D - sz) np = D - sz;
    if (nq > sz) nq = sz;
`endif
    wen0 = w0; wen1 = w1; din0 = d0; din1 = d1; ren0 = r0; ren1 = r1;
    @(posedge clk);
    #1;
    for (int i = 0; i < nq; i++) void'(q.pop_front());
    if (np >= 1) q.push_back(d0);
    if (np >= 2) q.push_back(d1);
    check_state(tag, q.size(), (q.size() > 0) ? int'(q[0]) : 0, (q.size() > 1) ? int'(q[1]) : 0);
    idle();
  endtask

  initial begin
    // w0 w1 d0 d1 r0 r1 | count dout0 dout1
    vt[0]  = '{1'b0, 1'b0, 6'h00, 6'h00, 1'b1, 1'b1, 14, 'h02, 'h03};
    vt[1]  = '{1'b0, 1'b0, 6'h00, 6'h00, 1'b1, 1'b1, 12, 'h04, 'h05};
    vt[2]  = '{1'b0, 1'b0, 6'h00, 6'h00, 1'b1, 1'b1, 10, 'h06, 'h07};
    vt[3]  = '{1'b0, 1'b0, 6'h00, 6'h00, 1'b1, 1'b1, 8,  'h08, 'h09};
    vt[4]  = '{1'b0, 1'b0, 6'h00, 6'h00, 1'b1, 1'b1, 6,  'h0A, 'h0B};
    vt[5]  = '{1'b0, 1'b0, 6'h00, 6'h00, 1'b1, 1'b1, 4,  'h0C, 'h0D};
    vt[6]  = '{1'b0, 1'b0, 6'h00, 6'h00, 1'b1, 1'b1, 2,  'h0E, 'h0F};
    vt[7]  = '{1'b0, 1'b0, 6'h00, 6'h00, 1'b1, 1'b1, 0,  0,    0};
    vt[8]  = '{1'b1, 1'b1, 6'h2A, 6'h2B, 1'b0, 1'b0, 2,  'h2A, 'h2B};
    vt[9]  = '{1'b0, 1'b1, 6'h11, 6'h12, 1'b0, 1'b0, 2,  'h2A, 'h2B};
    vt[10] = '{1'b0, 1'b0, 6'h00, 6'h00, 1'b0, 1'b1, 2,  'h2A, 'h2B};
    vt[11] = '{1'b1, 1'b0, 6'h05, 6'h33, 1'b0, 1'b0, 3,  'h2A, 'h2B};
    vt[12] = '{1'b0, 1'b0, 6'h00, 6'h00, 1'b1, 1'b0, 2,  'h2B, 'h05};
    vt[13] = '{1'b1, 1'b1, 6'h06, 6'h07, 1'b0, 1'b0, 4,  'h2B, 'h05};
    vt[14] = '{1'b1, 1'b1, 6'h08, 6'h09, 1'b0, 1'b0, 6,  'h2B, 'h05};
    vt[15] = '{1'b1, 1'b1, 6'h0A, 6'h0B, 1'b0, 1'b0, 8,  'h2B, 'h05};
    vt[16] = '{1'b1, 1'b1, 6'h0C, 6'h0D, 1'b1, 1'b1, 8,  'h06, 'h07};
    vt[17] = '{1'b1, 1'b0, 6'h0E, 6'h15, 1'b1, 1'b1, 7,  'h08, 'h09};
    vt[18] = '{1'b0, 1'b0, 6'h21, 6'h22, 1'b1, 1'b1, 5,  'h0A, 'h0B};
    vt[19] = '{1'b1, 1'b1, 6'h3F, 6'h00, 1'b1, 1'b0, 6,  'h0B, 'h0C};
    vt[20] = '{1'b0, 1'b0, 6'h00, 6'h00, 1'b0, 1'b0, 6,  'h0B, 'h0C};

    resetn = 1'b0;
    idle();

    // Reset preload: full of IDs 0..15.
    do_reset();
    check_state("reset", 16, 'h00, 'h01);

    // Table: drain, refill, lane ordering, simultaneous push/pop.
    for (int i = 0; i < 21; i++) begin
      wen0 = vt[i].w0; wen1 = vt[i].w1; din0 = vt[i].d0; din1 = vt[i].d1;
      ren0 = vt[i].r0; ren1 = vt[i].r1;
      @(posedge clk);
      #1;
      check_state($sformatf("vec%0d", i), vt[i].cnt, vt[i].o0, vt[i].o1);
    end
    idle();

    // Wrap: pop 15, push 15, then dual push/pop across the 15->0 boundary.
    do_reset();
    for (int i = 0; i < 15; i++) step("wrap_pop", 1'b0, 1'b0, 6'h00, 6'h00, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) step("wrap_push", 1'b1, 1'b0, 6'(8'h20 + i), 6'h00, 1'b0, 1'b0);
    step("wrap_pop2", 1'b0, 1'b0, 6'h00, 6'h00, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++)
      step("wrap_dual", 1'b1, 1'b1, 6'(8'h10 + 2*i), 6'(8'h11 + 2*i), 1'b1, 1'b1);

    // Asynchronous reset in mid-cycle with traffic applied.
    wen0 = 1'b1; wen1 = 1'b1; ren0 = 1'b1; ren1 = 1'b1; din0 = 6'h3A; din1 = 6'h3B;
    @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check_state("async_rst", 16, 'h00, 'h01);
    idle();
    @(negedge clk);
    resetn = 1'b1;
    #1;
    check_state("after_rst", 16, 'h00, 'h01);
    q.delete();
    for (int i = 0; i < D; i++) q.push_back(6'(i));

`ifdef COMMON_FIFO_RAM_2W2R_GUARD_EN
    // Full with push 1 and pop 1: the write is rejected.
    step("g_full_pp", 1'b1, 1'b0, 6'h31, 6'h00, 1'b1, 1'b0);
    // count 15 with a dual push: only din0 is stored.
    step("g_push15", 1'b1, 1'b1, 6'h32, 6'h33, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) step("g_drain", 1'b0, 1'b0, 6'h00, 6'h00, 1'b1, 1'b1);
    step("g_pop1", 1'b0, 1'b0, 6'h00, 6'h00, 1'b1, 1'b0);
    // count 1 with a dual pop: ren1 is ignored.
    step("g_single", 1'b0, 1'b0, 6'h00, 6'h00, 1'b1, 1'b1);
    step("g_wen1", 1'b0, 1'b1, 6'h34, 6'h35, 1'b0, 1'b0);
    step("g_under", 1'b0, 1'b0, 6'h00, 6'h00, 1'b1, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/common_fifo_ram_2w2r.md
# common_fifo_ram_2w2r

Two-wide, parametrised RAM-based FIFO with programmable reset preload. Up to two entries can be pushed and up to two popped per cycle. Both head entries are visible combinationally (first-word-fall-through). It is the dual-lane successor to the single-port preloaded FIFO and serves as the 2-wide physical-register free list in rename: reset full of IDs 0..N-1, allocate two, release two per cycle.

## Interface
- FIFO_DEPTH_LOG2, 4, log2 of entry count; DEPTH = 2^FIFO_DEPTH_LOG2, minimum 2
- FIFO_WIDTH, 6, entry width in bits
- FIFO_RESET_STATE, 16, occupancy after reset; width FIFO_DEPTH_LOG2+1; range 0..DEPTH
- FIFO_RESET_VALUE, {0,1,..,15}, DEPTH*FIFO_WIDTH packed preload; entry k = bits [(DEPTH-1-k)*FIFO_WIDTH +: FIFO_WIDTH], so the first concatenated field is entry 0

Ports:
- clk  in  1  clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- din0  in  FIFO_WIDTH  write data, lane 0 (older)
- din1  in  FIFO_WIDTH  write data, lane 1 (younger)
- wen0  in  1  push lane 0
- wen1  in  1  push lane 1; meaningful only with wen0
- dout0  out  FIFO_WIDTH  head entry (oldest)
- dout1  out  FIFO_WIDTH  head+1 entry
- ren0  in  1  pop head
- ren1  in  1  pop head+1; meaningful only with ren0
- fifo_count  out  FIFO_DEPTH_LOG2+1  current occupancy
- fifo_empty  out  1  count == 0
- fifo_single  out  1  count <= 1 (dout1 not valid)
- fifo_full  out  1  count == DEPTH
- fifo_full2  out  1  count >= DEPTH-1 (two pushes not possible)

## Operation
- State registers:
  - mem[DEPTH]
  - rptr and wptr, each FIFO_DEPTH_LOG2+1 bits including a wrap bit
  - count = wptr - rptr (modulo 2^(FIFO_DEPTH_LOG2+1)), computed combinationally
- Reset (resetn low, asynchronous):
  - mem[k] = FIFO_RESET_VALUE entry k
  - rptr = 0; wptr = FIFO_RESET_STATE
  - Outputs then reflect that state. Default parameters give count=16, full=1, full2=1, empty=0, single=0, dout0=0, dout1=1.
- Reads:
  - dout0 = mem[rptr mod DEPTH]; dout1 = mem[(rptr+1) mod DEPTH]. Both are purely combinational from registers.
  - Contents are undefined when the entry is not occupied.
  - The number of pops npop is 0, 1 or 2. rptr advances by npop at the clock edge.
- Writes:
  - din0 is written to mem[wptr mod DEPTH]; din1 is written to mem[(wptr+1) mod DEPTH].
  - The number of pushes npush is 0, 1 or 2. wptr advances by npush.
- Lane ordering: lane 1 acts only together with lane 0.
  - wen1 without wen0 gives npush=0.
  - ren1 without ren0 gives npop=0.
- Simultaneous push and pop:
  - Both pointers update in the same edge; net count change = npush - npop.
  - Acceptance is decided on pre-edge count only: no same-cycle credit from pops to pushes, and no bypass from pushes to pops.
- Wrap-around: the pointer index is taken modulo DEPTH; the wrap bit distinguishes full from empty. The lane-1 address wraps independently (wptr = DEPTH-1 makes lane 1 write entry 0).
- Reset mid-operation: asynchronous, overrides everything, including any in-flight edge. All state returns to the reset preload.

## Timing
- Push-to-visible latency: 1 cycle. Data pushed at edge t appears on dout from edge t if it becomes the head.
- Pop: dout0/dout1 change right after the edge that pops.
- Status outputs (count, empty, single, full, full2) update in the same cycle as the pointers. They are combinational from the pointer registers, with no extra latency.

## Configuration
- COMMON_FIFO_RAM_2W2R_GUARD_EN defined (guarded mode):
  - npush is clipped to the free space DEPTH - count: a lane-1 write is dropped when count = DEPTH-1, and all writes are dropped when full.
  - npop is clipped to count: ren1 is ignored when count = 1, and all reads are ignored when empty.
  - Dropped lanes leave mem and the pointers untouched.
- Undefined (unguarded mode):
  - npush = wen0 + (wen0 & wen1) and npop = ren0 + (ren0 & ren1), with no clipping.
  - Overflow and underflow corrupt pointers. The caller must guarantee legality; in exchange, area and timing are smaller.

## Test plan
- Reset with default parameters, hold 3 cycles, release -> count=16, full=1, full2=1, empty=0, dout0=0, dout1=1.
- ren0=ren1=1 for 8 cycles from reset -> dout pairs (0,1),(2,3),...,(14,15) observed; then count=0, empty=1, single=1.
- From empty, wen0=wen1=1 with din0=0x2A, din1=0x2B -> next cycle count=2, dout0=0x2A, dout1=0x2B, single=0.
- Wrap: pop 15, push 15 distinct values, then dual-push/dual-pop for 20 cycles -> FIFO order preserved across the index 15->0 boundary, including a lane-1 write landing at entry 0.
- Simultaneous at count=8: push 2 and pop 2 -> count stays 8, dout0 is the old head+2. Push 1 and pop 2 -> count=7.
- Guard (GUARD_EN): count=15 with wen0=wen1=1 -> count=16 and only din0 stored. count=1 with ren0=ren1=1 -> count=0. wen1 alone -> no change. Full with push 1 and pop 1 -> count=15 (the write is rejected).
